serial_tx: RTL and testbench
============================

# serial_tx

Frame-based serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line as start bit, data bits LSB-first, and stop bit, each held for a fixed number of clock cycles. It is the sending end of the team's serial link, built on the same registered-flip-flop style as the storage primitives. Its counterpart is a serial receiver that samples the line and reassembles words.

## Interface
- `DATA_W`, default 8: data bits per frame; must be ≥ 1.
- `CLKS_PER_BIT`, default 4: clock cycles each line bit is held; must be ≥ 2.
- `clk`, input, 1: single clock; all state updates on the posedge.
- `clr_n`, input, 1: reset, asynchronous, active-low.
- `data`, input, `DATA_W`: word to send; sampled only on an accepted handshake.
- `valid`, input, 1: `data` is offered.
- `ready`, output, 1: high only in IDLE; a word is accepted at a posedge where `valid & ready`.
- `tx`, output, 1: serial line, registered; idles high.
- `busy`, output, 1: high from the cycle after acceptance through the last stop-bit cycle.
- `done`, output, 1: one-cycle pulse in the first IDLE cycle after a frame completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE:** `tx`=1, `ready`=1. On `valid` at a posedge:
  - latch `data` into the shift register;
  - clear the tick counter and bit index;
  - go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx` = shift-register bit 0;
  - each time the tick counter reaches `CLKS_PER_BIT`-1, shift right and increment the bit index;
  - after bit `DATA_W`-1 completes, go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE with `done`=1 for exactly that first IDLE cycle.
- **Ignored inputs while not in IDLE:**
  - `valid` is ignored; there is no queuing or backpressure beyond `ready`=0;
  - changes on `data` have no effect on the frame in flight.
- **Counters:**
  - tick counter is `$clog2(CLKS_PER_BIT)` bits and wraps to 0 at `CLKS_PER_BIT`-1;
  - bit index is `$clog2(DATA_W)` bits (minimum width 1).
- **Back-to-back:** `ready` is high in the same cycle `done` pulses, so the next word can be accepted at that posedge. The line then shows stop-level for `CLKS_PER_BIT`+1 cycles between frames; this gap is the minimum.
- **Reset:**
  - asserting `clr_n` low at any time (including mid-frame) immediately forces IDLE, `tx`=1, `busy`=0, `done`=0, `ready`=1;
  - the frame is abandoned, with no `done` and no partial replay after release.
- **Reset values:** `tx`=1, `ready`=1, `busy`=0, `done`=0; shift register, tick counter and bit index are 0.

## Timing
Let accept occur at posedge k, with N=`DATA_W` and C=`CLKS_PER_BIT`.
- Start bit: `tx`=0 and `busy`=1 in cycles k+1 … k+C.
- Data bit i: on `tx` in cycles k+1+C(1+i) … k+C(2+i).
- Stop bit: `tx`=1 in cycles k+1+C(N+1) … k+C(N+2).
- Frame end: at posedge k+C(N+2), state becomes IDLE, `busy`=0, `ready`=1, `done`=1 for one cycle.
- Frame length is C(N+2) cycles from accept to `done`; latency from accept to the first `tx` change is 1 cycle.
- All outputs are registered or decoded from the registered state only; there is no combinational path from `valid`/`data` to any output.

## Test plan
- **Reset values:** hold `clr_n`=0 for 3 cycles, then release → `tx`=1, `ready`=1, `busy`=0, `done`=0 both during and after reset.
- **Single frame** (`DATA_W`=8, `CLKS_PER_BIT`=4): send 0xA5 → `tx` carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `done` pulses exactly 40 cycles after accept; `busy` is high for 40 cycles.
- **Back-to-back:** 0x00, then 0xFF offered with `valid` held high → second accept occurs in the `done` cycle; line gap between the frames is 5 cycles high; second frame is 0, eight 1s, 1.
- **Ignored inputs:** toggle `valid` and randomize `data` during a 0x3C frame → serialized bits still equal 0x3C, with no extra frame and no extra `done`.
- **Mid-frame reset:** assert `clr_n`=0 at the 3rd data bit → `tx`=1 immediately without waiting for `clk`; after release the state is IDLE, `ready`=1, and no `done` ever fires for that frame.
- **Minimum parameters** (`CLKS_PER_BIT`=2, `DATA_W`=1): send 1 → `tx` shows 0,0,1,1,1,1; `done` at accept+6.

Source files
------------

// File: rtl/serial_tx.sv
// Frame-based serial transmitter: start bit, DATA_W data bits LSB-first, stop bit,
// each held CLKS_PER_BIT clocks. Word accepted over a valid/ready handshake in IDLE.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic                tx_q,    tx_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                tick_last;

  assign tick_last = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d = data;
          tick_d  = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
        if (tick_last) state_d = DATA;
      end
      DATA: begin
        tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
        if (tick_last) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
        if (tick_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so tx is a clean register output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Randomized bench for serial_tx: two instances (8/4 and minimum 1/2) compared every
// cycle against a queue-of-line-levels frame model, plus directed latency/reset checks.
module tb_serial_tx;

  localparam int NA = 8, CA = 4;
  localparam int NB = 1, CB = 2;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0] data_a  = '0;
  logic          valid_a = 1'b0;
  logic          ready_a, tx_a, busy_a, done_a;
  logic [NB-1:0] data_b  = '0;
  logic          valid_b = 1'b0;
  logic          ready_b, tx_b, busy_b, done_b;

  serial_tx #(.DATA_W(NA), .CLKS_PER_BIT(CA)) u_dut_a (
    .clk(clk), .clr_n(clr_n), .data(data_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  serial_tx #(.DATA_W(NB), .CLKS_PER_BIT(CB)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .data(data_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a frame is just the list of line levels, one per clock, from accept+1 on.
  typedef bit bq_t[$];

  function automatic bq_t frame(input logic [31:0] d, input int n, input int c);
    bq_t q;
    for (int i = 0; i < c; i++) q.push_back(1'b0);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < c; i++) q.push_back(d[b]);
    for (int i = 0; i < c; i++) q.push_back(1'b1);
    return q;
  endfunction

  bq_t qa, qb;
  bit  done_ma = 1'b0, done_mb = 1'b0;

  initial forever begin
    @(posedge clk or negedge clr_n);
    if (!clr_n) begin
      qa.delete(); done_ma = 1'b0;
      qb.delete(); done_mb = 1'b0;
    end else begin
      if (qa.size() != 0) begin
        void'(qa.pop_front());
        done_ma = (qa.size() == 0);
      end else begin
        done_ma = 1'b0;
        if (valid_a) qa = frame(32'(data_a), NA, CA);
      end
      if (qb.size() != 0) begin
        void'(qb.pop_front());
        done_mb = (qb.size() == 0);
      end else begin
        done_mb = 1'b0;
        if (valid_b) qb = frame(32'(data_b), NB, CB);
      end
    end
  end

  initial forever begin
    bit etx;
    @(negedge clk);
    etx = (qa.size() != 0) ? qa[0] : 1'b1;
    check("a_tx",    32'(tx_a),    32'(etx));
    check("a_busy",  32'(busy_a),  32'(qa.size() != 0));
    check("a_ready", 32'(ready_a), 32'(qa.size() == 0));
    check("a_done",  32'(done_a),  32'(done_ma));
    etx = (qb.size() != 0) ? qb[0] : 1'b1;
    check("b_tx",    32'(tx_b),    32'(etx));
    check("b_busy",  32'(busy_b),  32'(qb.size() != 0));
    check("b_ready", 32'(ready_b), 32'(qb.size() == 0));
    check("b_done",  32'(done_b),  32'(done_mb));
  end

  // Returns just after the accepting posedge.
  task automatic send_a(input logic [NA-1:0] d);
    int t;
    data_a = d; valid_a = 1'b1; t = 0;
    while (!ready_a && t < 200) begin @(posedge clk); #1; t++; end
    check("a_accept_timeout", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [NB-1:0] d);
    int t;
    data_b = d; valid_b = 1'b1; t = 0;
    while (!ready_b && t < 200) begin @(posedge clk); #1; t++; end
    check("b_accept_timeout", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_a || busy_b) && t < 500) begin @(posedge clk); #1; t++; end
    check("idle_timeout", 32'(t < 500), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, b, dcnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",    32'(tx_a),    32'd1);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tx",    32'(tx_a),    32'd1);
    check("post_rst_ready", 32'(ready_a), 32'd1);
    check("post_rst_busy",  32'(busy_a),  32'd0);
    check("post_rst_done",  32'(done_a),  32'd0);

    // Single frame 0xA5: done latency and busy length.
    send_a(8'hA5);
    n = 0; b = busy_a ? 1 : 0;
    while (!done_a && n < 100) begin
      @(posedge clk); #1; n++;
      if (busy_a) b++;
    end
    check("a5_done_latency", 32'(n), 32'd40);
    check("a5_busy_cycles",  32'(b), 32'd40);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back with valid held high.
    data_a = 8'h00; valid_a = 1'b1; n = 0;
    while (!ready_a && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    data_a = 8'hFF; n = 0;
    while (!ready_a && n < 200) begin @(posedge clk); #1; n++; end
    check("b2b_ready_in_done_cycle", 32'(done_a), 32'd1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    check("b2b_second_accepted", 32'(busy_a), 32'd1);
    wait_idle();

    // Inputs wiggling during a 0x3C frame must not disturb it.
    send_a(8'h3C);
    for (int i = 0; i < CA * (NA + 2) - 2; i++) begin
      valid_a = 1'($urandom);
      data_a  = 8'($urandom);
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    wait_idle();

    // Random frames with random idle gaps.
    repeat (6) begin
      send_a(8'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Mid-frame reset during data bit 2 of 0x5A (bit value 0).
    send_a(8'h5A);
    repeat (3 * CA + 1) @(posedge clk);
    @(negedge clk); #2;
    check("pre_rst_tx_low", 32'(tx_a), 32'd0);
    clr_n = 1'b0;
    #1;
    check("midrst_tx",    32'(tx_a),    32'd1);
    check("midrst_busy",  32'(busy_a),  32'd0);
    check("midrst_ready", 32'(ready_a), 32'd1);
    check("midrst_done",  32'(done_a),  32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    dcnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done_a) dcnt++;
    end
    check("midrst_no_done",  32'(dcnt),    32'd0);
    check("midrst_idle_rdy", 32'(ready_a), 32'd1);

    // Minimum parameters: send 1, done at accept+6.
    send_b(1'b1);
    n = 0;
    while (!done_b && n < 50) begin @(posedge clk); #1; n++; end
    check("min_done_latency", 32'(n), 32'd6);
    wait_idle();
    send_b(1'b0);
    wait_idle();
    repeat (4) begin
      send_b(1'($urandom));
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
